fp_round_int: RTL and testbench

Pipelined, parametrised floating-point round-to-integral unit. It rounds an IEEE 754 value to an integral value in the same format under one of five rounding modes and raises inexact and invalid flags. It sits in the FPU as the successor to the single-cycle, 32-bit, truncate-only converter. Widths scale with `FPWID`, and a valid/ready handshake with backpressure replaces the bare clock enable.

---
 rtl/fp_round_int.sv | 179 +++++++++++++++++
 tb/tb_fp_round_int.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_int.sv
// Purpose: rounds an IEEE 754 operand to an integral value in the same format (5 modes, inexact/invalid flags).
// Latency: 2 cycles from the accepting edge to out_valid, 1 result per cycle when unstalled.
// Backpressure: valid/ready; out_ready low holds S2 and a full S1, in_ready drops once both are full; ce=0 freezes all.
module fp_round_int #(
    parameter int FPWID = 32,
    parameter int TAGW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FPWID-1:0]  i,
    input  logic [2:0]        rm,
    input  logic [TAGW-1:0]   tag_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FPWID-1:0]  o,
    output logic [TAGW-1:0]   tag_o,
    output logic              inexact,
    output logic              invalid
);

    // Exponent width per format; fraction takes the rest after the sign.
    localparam int EW   = (FPWID == 16) ? 5 : (FPWID == 32) ? 8 : (FPWID == 64) ? 11 : 15;
    localparam int FW   = FPWID - 1 - EW;
    localparam int EMSB = EW - 1;
    // FMSB is the bit position of the hidden bit in the significand.
    localparam int FMSB = FW;
    localparam int MW   = FPWID - 1;
    localparam int BIAS = (1 << EMSB) - 1;

    localparam logic [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic [EW-1:0] E_HALF = EW'(BIAS - 1);
    localparam logic [EW-1:0] E_INT  = EW'(BIAS + FMSB);
    localparam logic [MW-1:0] LSB1   = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] ONE    = {E_BIAS, {FW{1'b0}}};
    localparam logic [MW-1:0] QBIT   = {{EW{1'b0}}, 1'b1, {(FW-1){1'b0}}};

    // Operand fields
    logic          sgn;
    logic [EW-1:0] exp_f;
    logic [FW-1:0] frac;
    logic [MW-1:0] mag;

    assign sgn   = i[FPWID-1];
    assign mag   = i[MW-1:0];
    assign exp_f = i[MW-1:FW];
    assign frac  = i[FW-1:0];

    // Fraction-bit count and the masks derived from it (only meaningful for bias <= exp < bias+FMSB)
    logic [EW-1:0] fcnt;
    logic [MW-1:0] inc_m;
    logic [MW-1:0] lo_m;
    logic [MW-1:0] rnd_m;
    logic [MW-1:0] stk_m;

    assign fcnt  = E_INT - exp_f;
    assign inc_m = LSB1 << fcnt;
    assign lo_m  = inc_m - LSB1;
    assign rnd_m = inc_m >> 1;
    assign stk_m = lo_m >> 1;

    // S1 next-state: classification, masked magnitude, and the amount to add in S2
    logic          rnd;
    logic          stk;
    logic          lsb;
    logic          up;
    logic [MW-1:0] nx_mag;
    logic [MW-1:0] nx_inc;
    logic [MW-1:0] nx_add;
    logic          nx_inx;
    logic          nx_inv;

    // Decode operand and decide rounding direction
    always_comb begin
        rnd    = 1'b0;
        stk    = 1'b0;
        lsb    = 1'b0;
        up     = 1'b0;
        nx_mag = mag;
        nx_inc = '0;
        nx_add = '0;
        nx_inx = 1'b0;
        nx_inv = 1'b0;
        if (&exp_f) begin
            // Inf and quiet NaN pass; signalling NaN gets its quiet bit set
            if ((|frac) && !frac[FW-1]) begin
                nx_mag = mag | QBIT;
                nx_inv = 1'b1;
            end
        end else if ((exp_f == '0) && !(|frac)) begin
            nx_mag = mag;
        end else if (exp_f >= E_INT) begin
            nx_mag = mag;
        end else begin
            if (exp_f >= E_BIAS) begin
                rnd    = |(mag & rnd_m);
                stk    = |(mag & stk_m);
                // At f = FMSB this picks the exponent LSB, which is 1 just like the hidden bit
                lsb    = |(mag & inc_m);
                nx_mag = mag & ~lo_m;
                nx_inc = inc_m;
            end else begin
                // Magnitude below 1: result is zero or one with the operand's sign
                rnd    = (exp_f == E_HALF);
                stk    = rnd ? (|frac) : 1'b1;
                lsb    = 1'b0;
                nx_mag = '0;
                nx_inc = ONE;
            end
            nx_inx = rnd | stk;
            case (rm)
                3'b000:  up = rnd & (stk | lsb);
                3'b100:  up = rnd;
                3'b011:  up = !sgn & (rnd | stk);
                3'b010:  up = sgn & (rnd | stk);
                default: up = 1'b0;
            endcase
            nx_add = up ? nx_inc : '0;
        end
    end

    // Pipeline control
    logic            s1_vld;
    logic            s1_sgn;
    logic [MW-1:0]   s1_mag;
    logic [MW-1:0]   s1_add;
    logic            s1_inx;
    logic            s1_inv;
    logic [TAGW-1:0] s1_tag;
    logic            s1_adv;

    assign s1_adv   = !out_valid | out_ready;
    assign in_ready = rst_n & ce & (!s1_vld | s1_adv);

    // S1: capture decoded operand on an accepting edge, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_sgn <= 1'b0;
            s1_mag <= '0;
            s1_add <= '0;
            s1_inx <= 1'b0;
            s1_inv <= 1'b0;
            s1_tag <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_sgn <= sgn;
                s1_mag <= nx_mag;
                s1_add <= nx_add;
                s1_inx <= nx_inx;
                s1_inv <= nx_inv;
                s1_tag <= tag_i;
            end
        end
    end

    // S2: apply the increment (carry ripples into the exponent) and register outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            o         <= '0;
            tag_o     <= '0;
            inexact   <= 1'b0;
            invalid   <= 1'b0;
        end else if (ce && s1_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                o       <= {s1_sgn, s1_mag + s1_add};
                tag_o   <= s1_tag;
                inexact <= s1_inx;
                invalid <= s1_inv;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_int.sv
// Bench for fp_round_int: FP32 instance checked against an arithmetic reference model,
// plus an FP64 instance for one directed case and its latency.
module tb_fp_round_int;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] i;
    logic [2:0]  rm;
    logic [3:0]  tag_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] o;
    logic [3:0]  tag_o;
    logic        inexact;
    logic        invalid;

    logic        in_valid64;
    logic        in_ready64;
    logic [63:0] i64;
    logic [2:0]  rm64;
    logic [3:0]  tag_i64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] o64;
    logic [3:0]  tag_o64;
    logic        inexact64;
    logic        invalid64;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int results = 0;
    int bp_mode = 0;
    logic [37:0] exp_q[$];

    always #5 clk = ~clk;

    fp_round_int #(.FPWID(32), .TAGW(4)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .i(i), .rm(rm), .tag_i(tag_i), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .tag_o(tag_o), .inexact(inexact), .invalid(invalid)
    );

    fp_round_int #(.FPWID(64), .TAGW(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid64), .in_ready(in_ready64),
        .i(i64), .rm(rm64), .tag_i(tag_i64), .out_valid(out_valid64), .out_ready(out_ready64),
        .o(o64), .tag_o(tag_o64), .inexact(inexact64), .invalid(invalid64)
    );

    // Reference: value = sig * 2^(E-150); split into integer quotient and remainder,
    // round the quotient by comparing the remainder to one half, then renormalise.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [2:0] m);
        logic        s;
        int          e;
        int          ee;
        int          f;
        int          p;
        logic [22:0] fr;
        longint      sig;
        longint      q;
        longint      rem;
        longint      half;
        logic        up;
        logic [31:0] r;
        logic [2:0]  mm;
        s  = x[31];
        e  = int'(x[30:23]);
        fr = x[22:0];
        if (e == 255) begin
            if (fr != 0 && !fr[22]) return {2'b01, x | 32'h0040_0000};
            return {2'b00, x};
        end
        if (e == 0 && fr == 0) return {2'b00, x};
        sig = (e == 0) ? longint'(fr) : longint'(fr) + 64'sd8388608;
        ee  = (e == 0) ? 1 : e;
        if (ee >= 150) return {2'b00, x};
        f = 150 - ee;
        if (f > 40) begin
            q    = 0;
            rem  = sig;
            half = 64'sd1 <<< 40;
        end else begin
            q    = sig >>> f;
            rem  = sig - (q <<< f);
            half = 64'sd1 <<< (f - 1);
        end
        mm = (m > 3'd4) ? 3'd1 : m;
        case (mm)
            3'd0:    up = (rem > half) || (rem == half && q[0]);
            3'd2:    up = s && (rem != 0);
            3'd3:    up = !s && (rem != 0);
            3'd4:    up = (rem >= half);
            default: up = 1'b0;
        endcase
        if (up) q = q + 1;
        if (q == 0) begin
            r = {s, 31'd0};
        end else begin
            p = 0;
            for (int k = 0; k < 25; k++) if (q[k]) p = k;
            r = {s, 8'(127 + p), 23'(q <<< (23 - p))};
        end
        return {(rem != 0), 1'b0, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until accepted
    task automatic send(input logic [31:0] v, input logic [2:0] m, input logic [3:0] t);
        bit ok;
        i        = v;
        rm       = m;
        tag_i    = t;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: operand %h never accepted", v);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          r;
        v = $urandom;
        r = $urandom_range(0, 9);
        if (r < 8)       v[30:23] = 8'($urandom_range(110, 155));
        else if (r == 8) v[30:23] = 8'hFF;
        else             v[30:23] = 8'h00;
        return v;
    endfunction

    // Output consumer: ready pattern selected by the main sequence
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard: record accepted operands, check every valid output against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back({tag_i, model(i, rm)});
                accepts++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL spurious_result: o=%h tag=%h with nothing outstanding", o, tag_o);
                end else begin
                    chk("result", 64'({tag_o, inexact, invalid, o}), 64'(exp_q[0]));
                    if (out_ready && ce) begin
                        void'(exp_q.pop_front());
                        results++;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [31:0] dv[13];
    logic [2:0]  dm[13];
    logic [33:0] dx[13];

    initial begin
        int a0;
        int r0;
        int lat;
        bit got;
        logic [31:0] va;

        rst_n = 1'b1; ce = 1'b1; in_valid = 1'b0; i = '0; rm = '0; tag_i = '0;
        in_valid64 = 1'b0; i64 = '0; rm64 = 3'd0; tag_i64 = 4'd0; out_ready64 = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_o",         64'(o),         64'd0);
        chk("rst_tag_o",     64'(tag_o),     64'd0);
        chk("rst_flags",     64'({inexact, invalid}), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'(ce));

        // Directed operands with hand-computed results {inexact, invalid, result}
        dv[0]  = 32'h4020_0000; dm[0]  = 3'd0; dx[0]  = {2'b10, 32'h4000_0000};
        dv[1]  = 32'h3FC0_0000; dm[1]  = 3'd0; dx[1]  = {2'b10, 32'h4000_0000};
        dv[2]  = 32'h3F00_0000; dm[2]  = 3'd0; dx[2]  = {2'b10, 32'h0000_0000};
        dv[3]  = 32'h4020_0000; dm[3]  = 3'd4; dx[3]  = {2'b10, 32'h4040_0000};
        dv[4]  = 32'h3F00_0000; dm[4]  = 3'd4; dx[4]  = {2'b10, 32'h3F80_0000};
        dv[5]  = 32'hBE99_999A; dm[5]  = 3'd3; dx[5]  = {2'b10, 32'h8000_0000};
        dv[6]  = 32'h3E99_999A; dm[6]  = 3'd2; dx[6]  = {2'b10, 32'h0000_0000};
        dv[7]  = 32'h4AFF_FFFF; dm[7]  = 3'd0; dx[7]  = {2'b10, 32'h4B00_0000};
        dv[8]  = 32'h4B00_0000; dm[8]  = 3'd0; dx[8]  = {2'b00, 32'h4B00_0000};
        dv[9]  = 32'h7F80_0001; dm[9]  = 3'd0; dx[9]  = {2'b01, 32'h7FC0_0001};
        dv[10] = 32'hFF80_0000; dm[10] = 3'd0; dx[10] = {2'b00, 32'hFF80_0000};
        dv[11] = 32'h7FC0_0000; dm[11] = 3'd0; dx[11] = {2'b00, 32'h7FC0_0000};
        dv[12] = 32'h3FC0_0000; dm[12] = 3'd6; dx[12] = {2'b10, 32'h3F80_0000};
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("model_%h_rm%0d", dv[k], dm[k]), 64'(model(dv[k], dm[k])), 64'(dx[k]));
            send(dv[k], dm[k], 4'(k));
        end
        drain();

        // FP64 instance: 2.5 under RNE, also checks the 2-cycle latency
        i64 = 64'h4004_0000_0000_0000;
        in_valid64 = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (in_ready64) got = 1'b1;
        end
        tick();
        in_valid64 = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (out_valid64) got = 1'b1;
            else lat++;
        end
        chk("fp64_latency", 64'(lat), 64'd2);
        chk("fp64_o", o64, 64'h4000_0000_0000_0000);
        chk("fp64_flags", 64'({inexact64, invalid64}), 64'b10);
        chk("fp64_tag", 64'(tag_o64), 64'd0);
        tick();

        // Backpressure: six tagged operands, consumer stalled for four cycles
        bp_mode = 1;
        a0 = accepts;
        fork
            begin
                for (int t = 0; t < 6; t++) send(rand_op(), 3'($urandom_range(0, 4)), 4'(t));
            end
            begin
                repeat (4) tick();
                chk("bp_accepts", 64'(accepts - a0), 64'd2);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                bp_mode = 0;
            end
        join
        drain();
        chk("bp_total", 64'(accepts - a0), 64'd6);

        // Reset with two operations in flight
        send(32'h4020_0000, 3'd0, 4'hA);
        send(32'h3FC0_0000, 3'd0, 4'hB);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_outputs", 64'({tag_o, inexact, invalid, o}), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end
        tick();

        // Enable held low for three cycles with the pipeline full
        send(32'h4049_0FDB, 3'd0, 4'h1);
        send(32'hC02D_F854, 3'd2, 4'h2);
        ce = 1'b0;
        va = 32'h3FC0_0000;
        i = va; rm = 3'd4; tag_i = 4'h3; in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("ce_in_ready", 64'(in_ready), 64'd0);
            chk("ce_out_valid", 64'(out_valid), 64'd1);
            chk("ce_queue_held", 64'(exp_q.size()), 64'd2);
            tick();
        end
        ce = 1'b1;
        send(va, 3'd4, 4'h3);
        drain();

        // Random operands and modes against a randomly stalling consumer
        r0 = results;
        bp_mode = 2;
        for (int n = 0; n < 400; n++) send(rand_op(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        bp_mode = 0;
        drain();
        chk("random_count", 64'(results - r0), 64'd400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
